// File: rtl/ldpc_ber_sweep_ctrl.sv
// ldpc_ber_sweep_ctrl
//   SNR-sweep sequencer for the LDPC BER tester datapath (data_clk domain).
//   One start pulse walks the AWGN factor across cfg_num_points points. At each
//   point the datapath counters are soft-reset, the datapath runs until the
//   block budget or the error budget is reached, in-flight blocks are drained,
//   and one result record is offered on the res_* handshake.
//
// Optional feature (macro LDPC_SWEEP_DRAIN_TIMEOUT_EN):
//   defined   - DRAIN gives up after 2**TIMEOUT_WIDTH-1 cycles, raises the sticky
//               timeout_err, drops the record and ends the sweep.
//   undefined - DRAIN waits indefinitely; timeout_err is tied low.
//
// Ports
//   data_clk, data_resetn          clock, async active-low reset
//   start, abort                   1-cycle control pulses
//   cfg_*                          sweep configuration, latched on accepted start
//   busy, done, timeout_err        sweep status
//   data_en, data_sw_resetn,
//   data_factor, data_offset       datapath control
//   data_finished_blocks,
//   data_bit_errors, data_in_flight datapath status
//   res_valid/res_ready, res_*     result record stream
//
// State table
//   IDLE   | waiting for start
//   SWRST  | datapath soft reset held low for RST_CYCLES cycles
//   SETTLE | waiting for datapath counters to read zero
//   RUN    | datapath enabled until block or error budget reached
//   DRAIN  | datapath disabled, waiting for in-flight blocks
//   REPORT | result record offered until accepted
//   NEXT   | advance point/factor or finish
//   FIN    | one-cycle done pulse

module ldpc_ber_sweep_ctrl #(
  parameter int RST_CYCLES    = 4,
  parameter int TIMEOUT_WIDTH = 20
) (
  input  logic        data_clk,
  input  logic        data_resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] cfg_factor_start,
  input  logic [15:0] cfg_factor_step,
  input  logic [7:0]  cfg_offset,
  input  logic [7:0]  cfg_num_points,
  input  logic [63:0] cfg_blocks_per_point,
  input  logic [63:0] cfg_max_errors,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        data_en,
  output logic        data_sw_resetn,
  output logic [15:0] data_factor,
  output logic [7:0]  data_offset,
  input  logic [63:0] data_finished_blocks,
  input  logic [63:0] data_bit_errors,
  input  logic [31:0] data_in_flight,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_point,
  output logic [15:0] res_factor,
  output logic [63:0] res_blocks,
  output logic [63:0] res_errors
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SWRST  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;
  localparam logic [2:0] S_NEXT   = 3'd6;
  localparam logic [2:0] S_FIN    = 3'd7;

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES - 1);

  if (RST_CYCLES < 1 || TIMEOUT_WIDTH < 2) begin : g_param_check
    $error("ldpc_ber_sweep_ctrl: RST_CYCLES must be >= 1 and TIMEOUT_WIDTH >= 2");
  end

  logic [2:0]    r_state;
  logic [2:0]    w_nxt;
  logic [RW-1:0] r_rst_cnt;
  logic          r_abort;
  logic          r_stop;
  logic [7:0]    r_point;
  logic [7:0]    r_num_points;
  logic [15:0]   r_factor;
  logic [15:0]   r_step;
  logic [7:0]    r_offset;
  logic [63:0]   r_budget;
  logic [63:0]   r_max_err;
  logic          r_busy;
  logic          r_done;
  logic          r_data_en;
  logic          r_sw_resetn;
  logic          r_res_valid;
  logic [7:0]    r_res_point;
  logic [15:0]   r_res_factor;
  logic [63:0]   r_res_blocks;
  logic [63:0]   r_res_errors;

  logic          w_latch;
  logic          w_capture;
  logic          w_advance;
  logic          w_to_hit;
  logic          w_stop_cond;
  logic [17:0]   w_sum;
  logic [15:0]   w_factor_sat;

  assign w_latch = (r_state == S_IDLE) && start;

  // 18 bits holds the full range of an unsigned 16-bit factor plus a signed
  // 16-bit step, so both saturation directions are visible in the top bits.
  assign w_sum = {2'b00, r_factor} + {{2{r_step[15]}}, r_step};
  always_comb begin
    w_factor_sat = w_sum[15:0];
    if (w_sum[17])      w_factor_sat = 16'h0000;
    else if (w_sum[16]) w_factor_sat = 16'hFFFF;
  end

  assign w_stop_cond = (data_finished_blocks >= r_budget) ||
                       ((r_max_err != 64'd0) && (data_bit_errors >= r_max_err));

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_nxt = (cfg_num_points == 8'd0) ? S_FIN : S_SWRST;
      S_SWRST:  if (abort) w_nxt = S_DRAIN;
                else if (r_rst_cnt == '0) w_nxt = S_SETTLE;
      S_SETTLE: if (abort) w_nxt = S_DRAIN;
                else if ((data_finished_blocks == 64'd0) && (data_bit_errors == 64'd0))
                  w_nxt = S_RUN;
      S_RUN:    if (abort || r_stop) w_nxt = S_DRAIN;
      S_DRAIN:  if (data_in_flight == 32'd0) w_nxt = (r_abort || abort) ? S_FIN : S_REPORT;
                else if (w_to_hit) w_nxt = S_FIN;
      S_REPORT: if (abort) w_nxt = S_FIN;
                else if (res_ready) w_nxt = S_NEXT;
      S_NEXT:   if (abort || r_abort || (r_point == 8'(r_num_points - 8'd1))) w_nxt = S_FIN;
                else w_nxt = S_SWRST;
      S_FIN:    w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  assign w_capture = (r_state == S_DRAIN) && (w_nxt == S_REPORT);
  assign w_advance = (r_state == S_NEXT) && (w_nxt == S_SWRST);

  // Outputs are registered from the next state so data_sw_resetn and data_en
  // reach the datapath glitch-free.
  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      r_state      <= S_IDLE;
      r_rst_cnt    <= RST_LOAD;
      r_abort      <= 1'b0;
      r_stop       <= 1'b0;
      r_point      <= 8'd0;
      r_num_points <= 8'd0;
      r_factor     <= 16'd0;
      r_step       <= 16'd0;
      r_offset     <= 8'd0;
      r_budget     <= 64'd1;
      r_max_err    <= 64'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_data_en    <= 1'b0;
      r_sw_resetn  <= 1'b1;
      r_res_valid  <= 1'b0;
      r_res_point  <= 8'd0;
      r_res_factor <= 16'd0;
      r_res_blocks <= 64'd0;
      r_res_errors <= 64'd0;
    end else begin
      r_state     <= w_nxt;
      r_busy      <= (w_nxt != S_IDLE) && (w_nxt != S_FIN);
      r_done      <= (w_nxt == S_FIN);
      r_data_en   <= (w_nxt == S_RUN);
      r_sw_resetn <= (w_nxt != S_SWRST);
      r_res_valid <= (w_nxt == S_REPORT);
      r_stop      <= (r_state == S_RUN) && w_stop_cond;

      if ((w_nxt == S_SWRST) && (r_state != S_SWRST)) r_rst_cnt <= RST_LOAD;
      else if (r_state == S_SWRST)                    r_rst_cnt <= r_rst_cnt - 1'b1;

      if (w_latch) begin
        r_abort      <= 1'b0;
        r_point      <= 8'd0;
        r_num_points <= cfg_num_points;
        r_factor     <= cfg_factor_start;
        r_step       <= cfg_factor_step;
        r_offset     <= cfg_offset;
        r_budget     <= (cfg_blocks_per_point == 64'd0) ? 64'd1 : cfg_blocks_per_point;
        r_max_err    <= cfg_max_errors;
      end else begin
        if (abort && (r_state != S_IDLE) && (r_state != S_FIN)) r_abort <= 1'b1;
        if (w_advance) begin
          r_point  <= r_point + 8'd1;
          r_factor <= w_factor_sat;
        end
      end

      if (w_capture) begin
        r_res_point  <= r_point;
        r_res_factor <= r_factor;
        r_res_blocks <= data_finished_blocks;
        r_res_errors <= data_bit_errors;
      end
    end
  end

`ifdef LDPC_SWEEP_DRAIN_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LOAD = {TIMEOUT_WIDTH{1'b1}} - 1'b1;

  logic [TIMEOUT_WIDTH-1:0] r_to_cnt;
  logic                     r_timeout_err;

  // Down-counter reloaded outside DRAIN; terminal count on the
  // (2**TIMEOUT_WIDTH-1)-th DRAIN cycle.
  assign w_to_hit = (r_to_cnt == '0);

  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      r_to_cnt      <= TO_LOAD;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != S_DRAIN) r_to_cnt <= TO_LOAD;
      else if (!w_to_hit)     r_to_cnt <= r_to_cnt - 1'b1;

      if (w_latch) r_timeout_err <= 1'b0;
      else if ((r_state == S_DRAIN) && (data_in_flight != 32'd0) && w_to_hit)
        r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_to_hit    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign busy           = r_busy;
  assign done           = r_done;
  assign data_en        = r_data_en;
  assign data_sw_resetn = r_sw_resetn;
  assign data_factor    = r_factor;
  assign data_offset    = r_offset;
  assign res_valid      = r_res_valid;
  assign res_point      = r_res_point;
  assign res_factor     = r_res_factor;
  assign res_blocks     = r_res_blocks;
  assign res_errors     = r_res_errors;

endmodule

// File: tb/tb_ldpc_ber_sweep_ctrl.sv
module tb_ldpc_ber_sweep_ctrl;

  logic        data_clk = 1'b0;
  logic        data_resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_factor_start = '0;
  logic [15:0] cfg_factor_step = '0;
  logic [7:0]  cfg_offset = '0;
  logic [7:0]  cfg_num_points = '0;
  logic [63:0] cfg_blocks_per_point = '0;
  logic [63:0] cfg_max_errors = '0;
  logic        busy, done, timeout_err, data_en, data_sw_resetn;
  logic [15:0] data_factor;
  logic [7:0]  data_offset;
  logic [63:0] m_fb = '0;
  logic [63:0] m_be = '0;
  logic [31:0] m_if = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  res_point;
  logic [15:0] res_factor;
  logic [63:0] res_blocks, res_errors;

  int          n_checks = 0;
  int          n_errors = 0;
  int          errs_per_blk = 0;
  logic        stuck = 1'b0;

  int          rec_cnt = 0;
  int          done_cnt = 0;
  int          rst_run = 0;
  int          last_rst_len = 0;
  logic [7:0]  rec_point[64];
  logic [15:0] rec_factor[64];
  logic [63:0] rec_blocks[64];
  logic [63:0] rec_errors[64];

  ldpc_ber_sweep_ctrl #(.RST_CYCLES(4), .TIMEOUT_WIDTH(4)) dut (
    .data_clk(data_clk), .data_resetn(data_resetn), .start(start), .abort(abort),
    .cfg_factor_start(cfg_factor_start), .cfg_factor_step(cfg_factor_step),
    .cfg_offset(cfg_offset), .cfg_num_points(cfg_num_points),
    .cfg_blocks_per_point(cfg_blocks_per_point), .cfg_max_errors(cfg_max_errors),
    .busy(busy), .done(done), .timeout_err(timeout_err), .data_en(data_en),
    .data_sw_resetn(data_sw_resetn), .data_factor(data_factor), .data_offset(data_offset),
    .data_finished_blocks(m_fb), .data_bit_errors(m_be), .data_in_flight(m_if),
    .res_valid(res_valid), .res_ready(res_ready), .res_point(res_point),
    .res_factor(res_factor), .res_blocks(res_blocks), .res_errors(res_errors)
  );

  always #5 data_clk = ~data_clk;

  // Datapath model: one block finishes per enabled cycle, two blocks stay in
  // flight and complete after data_en drops; stuck pins in_flight at 1.
  always @(posedge data_clk) begin
    if (data_sw_resetn === 1'b0) begin
      m_fb <= '0;
      m_be <= '0;
      m_if <= '0;
    end else begin
      if (data_en || (m_if != 0)) begin
        m_fb <= m_fb + 64'd1;
        m_be <= m_be + 64'(errs_per_blk);
      end
      if (data_en)        m_if <= 32'd2;
      else if (m_if != 0) m_if <= m_if - 32'd1;
      if (stuck)          m_if <= 32'd1;
    end
  end

  always @(negedge data_clk) begin
    if (res_valid === 1'b1 && res_ready === 1'b1 && rec_cnt < 64) begin
      rec_point[rec_cnt]  = res_point;
      rec_factor[rec_cnt] = res_factor;
      rec_blocks[rec_cnt] = res_blocks;
      rec_errors[rec_cnt] = res_errors;
      rec_cnt++;
    end
    if (done === 1'b1) done_cnt++;
    if (data_sw_resetn === 1'b0) rst_run++;
    else if (rst_run != 0) begin
      last_rst_len = rst_run;
      rst_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [7:0] np, input logic [15:0] fs, input logic [15:0] st,
                    input logic [63:0] blk, input logic [63:0] me);
    @(posedge data_clk); #1;
    cfg_num_points = np; cfg_factor_start = fs; cfg_factor_step = st;
    cfg_blocks_per_point = blk; cfg_max_errors = me;
    start = 1'b1;
    @(posedge data_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge data_clk); #1;
      n++;
    end
    chk(tag, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic wait_for(input int sel, input logic val, input string tag, input int budget);
    int n = 0;
    logic s;
    do begin
      @(negedge data_clk);
      s = (sel == 0) ? data_en : res_valid;
      n++;
    end while (s !== val && n < budget);
    chk(tag, s, val);
  endtask

  initial begin
    int r0;
    int n;
    logic ok;
    logic [15:0] snap_f;
    logic [63:0] snap_b, snap_e;

    // Reset state
    repeat (2) @(posedge data_clk);
    @(negedge data_clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_data_en", data_en, 1'b0);
    chk("rst_sw_resetn", data_sw_resetn, 1'b1);
    chk("rst_factor", data_factor, 16'h0);
    chk("rst_offset", data_offset, 8'h0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_blocks", res_blocks, 64'h0);
    @(posedge data_clk); #1;
    data_resetn = 1'b1;

    // T1: three-point sweep, plus a start pulse while busy that must be ignored
    res_ready = 1'b1; errs_per_blk = 0; cfg_offset = 8'h5A;
    r0 = rec_cnt;
    go(8'd3, 16'h1000, 16'h0100, 64'd10, 64'd0);
    chk("t1_busy", busy, 1'b1);
    repeat (3) @(posedge data_clk); #1;
    cfg_factor_start = 16'h7777; cfg_offset = 8'hC3; cfg_num_points = 8'd9;
    start = 1'b1;
    @(posedge data_clk); #1;
    start = 1'b0;
    wait_done("t1_done", 500);
    chk("t1_nrec", 64'(rec_cnt - r0), 64'd3);
    chk("t1_f0", rec_factor[r0], 16'h1000);
    chk("t1_f1", rec_factor[r0+1], 16'h1100);
    chk("t1_f2", rec_factor[r0+2], 16'h1200);
    chk("t1_p2", rec_point[r0+2], 8'd2);
    chk("t1_blk_ge", rec_blocks[r0] >= 64'd10, 1'b1);
    chk("t1_blk_le", rec_blocks[r0+1] <= 64'd20, 1'b1);
    chk("t1_err", rec_errors[r0+2], 64'd0);
    chk("t1_busy_low", busy, 1'b0);
    chk("t1_offset", data_offset, 8'h5A);
    chk("t1_rst_len", 64'(last_rst_len), 64'd4);
    repeat (3) @(negedge data_clk);
    chk("t1_one_done", 64'(done_cnt), 64'd1);

    // T2: error budget stops RUN early
    errs_per_blk = 2; r0 = rec_cnt;
    go(8'd1, 16'h2000, 16'h0, 64'd100, 64'd5);
    wait_done("t2_done", 500);
    chk("t2_nrec", 64'(rec_cnt - r0), 64'd1);
    chk("t2_err_ge", rec_errors[r0] >= 64'd5, 1'b1);
    chk("t2_blk_lt", rec_blocks[r0] < 64'd100, 1'b1);
    errs_per_blk = 0;

    // T3: negative step saturates at 0; positive step saturates at 0xFFFF
    r0 = rec_cnt;
    go(8'd3, 16'h0100, 16'hFF00, 64'd4, 64'd0);
    wait_done("t3_done", 500);
    chk("t3_f0", rec_factor[r0], 16'h0100);
    chk("t3_f1", rec_factor[r0+1], 16'h0000);
    chk("t3_f2", rec_factor[r0+2], 16'h0000);
    r0 = rec_cnt;
    go(8'd2, 16'hFF80, 16'h0100, 64'd0, 64'd0);
    wait_done("t3b_done", 500);
    chk("t3b_f1", rec_factor[r0+1], 16'hFFFF);
    chk("t3b_blk_ge1", rec_blocks[r0] >= 64'd1, 1'b1);

    // T4: backpressure in REPORT
    res_ready = 1'b0; r0 = rec_cnt;
    go(8'd1, 16'h3000, 16'h0, 64'd5, 64'd0);
    wait_for(1, 1'b1, "t4_valid", 200);
    snap_f = res_factor; snap_b = res_blocks; snap_e = res_errors;
    ok = 1'b1;
    repeat (50) begin
      @(negedge data_clk);
      if (res_valid !== 1'b1 || data_en !== 1'b0 || busy !== 1'b1 ||
          res_factor !== snap_f || res_blocks !== snap_b || res_errors !== snap_e) ok = 1'b0;
    end
    chk("t4_hold", ok, 1'b1);
    chk("t4_factor", snap_f, 16'h3000);
    @(posedge data_clk); #1;
    res_ready = 1'b1;
    wait_done("t4_done", 50);
    chk("t4_nrec", 64'(rec_cnt - r0), 64'd1);

    // T5: abort during RUN of point 1
    r0 = rec_cnt;
    go(8'd4, 16'h4000, 16'h0010, 64'd1000, 64'd0);
    n = 0;
    while (rec_cnt == r0 && n < 2000) begin @(negedge data_clk); #1; n++; end
    chk("t5_rec0", 64'(rec_cnt - r0), 64'd1);
    wait_for(0, 1'b1, "t5_run1", 100);
    repeat (5) @(posedge data_clk); #1;
    abort = 1'b1;
    @(posedge data_clk); #1;
    abort = 1'b0;
    @(negedge data_clk);
    chk("t5_en_drop", data_en, 1'b0);
    chk("t5_busy", busy, 1'b1);
    chk("t5_factor", data_factor, 16'h4010);
    wait_done("t5_done", 100);
    chk("t5_nrec", 64'(rec_cnt - r0), 64'd1);
    chk("t5_drained", m_if, 32'd0);
    r0 = rec_cnt;
    go(8'd1, 16'h5000, 16'h0, 64'd3, 64'd0);
    @(negedge data_clk);
    chk("t5_restart", busy, 1'b1);
    wait_done("t5b_done", 200);
    chk("t5b_factor", rec_factor[r0], 16'h5000);

    // num_points == 0 finishes at once without a record
    r0 = rec_cnt;
    go(8'd0, 16'h1111, 16'h0, 64'd3, 64'd0);
    @(negedge data_clk);
    chk("np0_done", done, 1'b1);
    chk("np0_busy", busy, 1'b0);
    chk("np0_nrec", 64'(rec_cnt - r0), 64'd0);

    // start and abort together in IDLE: start wins
    r0 = rec_cnt;
    @(posedge data_clk); #1;
    cfg_num_points = 8'd1; cfg_factor_start = 16'h2222; cfg_blocks_per_point = 64'd3;
    start = 1'b1; abort = 1'b1;
    @(posedge data_clk); #1;
    start = 1'b0; abort = 1'b0;
    wait_done("sa_done", 200);
    chk("sa_nrec", 64'(rec_cnt - r0), 64'd1);

`ifdef LDPC_SWEEP_DRAIN_TIMEOUT_EN
    // T6: drain timeout after 15 cycles
    stuck = 1'b1; r0 = rec_cnt;
    go(8'd2, 16'h6000, 16'h0, 64'd3, 64'd0);
    wait_for(0, 1'b1, "t6_run", 100);
    wait_for(0, 1'b0, "t6_drain", 100);
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      @(negedge data_clk);
      if (done !== 1'b1) n++;
    end
    chk("t6_drain_len", 64'(n), 64'd15);
    @(negedge data_clk); #1;
    chk("t6_timeout", timeout_err, 1'b1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_nrec", 64'(rec_cnt - r0), 64'd0);
    stuck = 1'b0;
    go(8'd1, 16'h6100, 16'h0, 64'd3, 64'd0);
    @(negedge data_clk);
    chk("t6_clear", timeout_err, 1'b0);
    wait_done("t6b_done", 200);
`else
    chk("t6_tied", timeout_err, 1'b0);
`endif

    // Async reset in the middle of RUN
    go(8'd2, 16'h7000, 16'h0, 64'd1000, 64'd0);
    wait_for(0, 1'b1, "ar_run", 100);
    #1;
    data_resetn = 1'b0;
    #1;
    chk("ar_busy", busy, 1'b0);
    chk("ar_data_en", data_en, 1'b0);
    chk("ar_sw_resetn", data_sw_resetn, 1'b1);
    chk("ar_factor", data_factor, 16'h0);
    chk("ar_offset", data_offset, 8'h0);
    chk("ar_res_factor", res_factor, 16'h0);
    @(posedge data_clk); #1;
    data_resetn = 1'b1;
    r0 = rec_cnt;
    go(8'd1, 16'h1234, 16'h0, 64'd2, 64'd0);
    wait_done("ar_post_done", 200);
    chk("ar_post_factor", rec_factor[r0], 16'h1234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
